// File: rtl/block_pkg.sv
// Shared block-map definitions for the block writer and block reader.
package block_pkg;

    localparam int unsigned ADDR_W      = 14;
    localparam int unsigned DATA_W      = 6;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned MAP_COLS    = 128;
    localparam int unsigned MAP_ROWS    = 128;
    localparam int unsigned MAP_IDX_W   = 7;
    localparam int unsigned BLOCK_SHIFT = 2;

    // Colour codes are RRGGBB 2:2:2.
    localparam logic [DATA_W-1:0] BORDER_COLOR     = 6'b000000;
    localparam logic [DATA_W-1:0] BLOCK_CODE_EMPTY = 6'b000000;
    localparam logic [DATA_W-1:0] BLOCK_CODE_WALL  = 6'b011001;
    localparam logic [DATA_W-1:0] BLOCK_CODE_WATER = 6'b000111;
    localparam logic [DATA_W-1:0] BLOCK_CODE_GRASS = 6'b001110;

    // Block RAM address layout: {row, col}.
    typedef struct packed {
        logic [MAP_IDX_W-1:0] row;
        logic [MAP_IDX_W-1:0] col;
    } block_addr_t;

    // Pixel coordinate to block index (not clamped).
    function automatic logic [COORD_W-1:0] to_block(input logic [COORD_W-1:0] c);
        return c >> BLOCK_SHIFT;
    endfunction

endpackage

// File: rtl/block_reader_fifo.sv
// Two-entry colour FIFO with registered storage and occupancy count.
module block_reader_fifo
    import block_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    // Pointer, storage and count update; push into a full FIFO only with a pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop & (count_q != 2'd0);
        do_push  = push & ((count_q != 2'd2) | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/block_reader.sv
// Pixel coordinate stream -> block RAM reads -> in-order colour stream.
// Optional BLOCK_READER_WR_STALL_EN adds wr_we to stall reads while the
// block writer owns a shared single-port RAM.
module block_reader
    import block_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef BLOCK_READER_WR_STALL_EN
    input  logic               wr_we,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);

    logic [COORD_W-1:0] col, row;
    block_addr_t        addr;
    logic               req_oob;
    logic               stall;
    logic               pop;
    logic               xfer;
    logic [1:0]         count;
    logic [2:0]         occupancy;
    logic               in_flight_q, in_flight_d;
    logic               oob_q, oob_d;
    logic [DATA_W-1:0]  push_data;

`ifdef BLOCK_READER_WR_STALL_EN
    assign stall = wr_we;
`else
    assign stall = 1'b0;
`endif

    // Address mapping, flow control and read strobe for the current request.
    always_comb begin
        col       = to_block(in_x);
        row       = to_block(in_y);
        req_oob   = (col >= COORD_W'(MAP_COLS)) | (row >= COORD_W'(MAP_ROWS));
        addr.row  = row[MAP_IDX_W-1:0];
        addr.col  = col[MAP_IDX_W-1:0];
        pop       = out_valid & out_ready;
        // Reserve a FIFO slot for every read already in flight.
        occupancy = 3'(count) + 3'(in_flight_q) - 3'(pop);
        in_ready  = (occupancy < 3'd2) & ~stall;
        xfer      = in_valid & in_ready & rst;
        rd_en     = xfer & ~req_oob;
        rd_addr   = addr;
    end

    // Stage-1 next state: track the request whose RAM data arrives next cycle.
    always_comb begin
        in_flight_d = xfer;
        oob_d       = xfer & req_oob;
        push_data   = oob_q ? BORDER_COLOR : rd_data;
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight_q <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            oob_q       <= oob_d;
        end
    end

    block_reader_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_block_reader.sv
// Scoreboard bench for block_reader with a behavioural 1-cycle-latency RAM.
module tb_block_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic       rd_en;
    logic [13:0] rd_addr;
    logic [5:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
`ifdef BLOCK_READER_WR_STALL_EN
    logic       wr_we = 1'b0;
`endif

    logic [5:0] ram [16384];
    logic [5:0] exp_q [$];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    block_reader dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BLOCK_READER_WR_STALL_EN
        .wr_we     (wr_we),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Synchronous-read block RAM model.
    initial begin
        for (int a = 0; a < 16384; a++) ram[a] = 6'((a * 7 + (a / 128) * 3) % 64);
        ram[131] = 6'b011001;
        ram[650] = 6'b000111;
        rd_data  = 6'd0;
    end

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: compare every output transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                check("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, record expected colour.
    task automatic send(input logic [9:0] x, input logic [9:0] y);
        int  waited = 0;
        int  col    = int'(x) / 4;
        int  row    = int'(y) / 4;
        bit  oob    = (col >= 128) || (row >= 128);
        int  addr   = row * 128 + col;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                n_total++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
                break;
            end
        end
        if (waited <= 200) begin
            check("rd_en", int'(rd_en), oob ? 0 : 1);
            if (!oob) check("rd_addr", int'(rd_addr), addr);
            exp_q.push_back(oob ? 6'b000000 : ram[addr]);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int rc;
        // Reset state, with a valid in-range request pending.
        rst = 1'b0; in_valid = 1'b1; in_x = 10'd13; in_y = 10'd6; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_rd_en", int'(rd_en), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Mapping and latency: (13,6) -> addr 131, data 011001 two cycles later.
        send(10'd13, 10'd6);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", int'(out_valid), 1);
        check("lat_cycle2_data", int'(out_data), 25);
        drain();

        // Out-of-range requests between in-range ones.
        send(10'd13, 10'd6);
        send(10'd600, 10'd10);
        send(10'd40, 10'd20);
        send(10'd8, 10'd700);
        send(10'd13, 10'd6);
        in_valid = 1'b0;
        drain();

        // Backpressure: exactly two accepted, then in_ready held low.
        out_ready = 1'b0;
        send(10'd20, 10'd24);
        send(10'd100, 10'd44);
        in_x = 10'd200; in_y = 10'd64;
        rc = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready || rd_en) rc++;
        end
        check("bp_ready_low", rc, 0);
        check("bp_full_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(10'd200, 10'd64);
        send(10'd300, 10'd500);
        in_valid = 1'b0;
        drain();

        // Reset mid-stream discards buffered and in-flight pixels.
        out_ready = 1'b0;
        send(10'd4, 10'd4);
        send(10'd8, 10'd8);
        in_x = 10'd12; in_y = 10'd12;
        #1 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_rd_en", int'(rd_en), 0);
        exp_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_empty", int'(out_valid), 0);
        @(posedge clk); #1;

        // Streaming: 256 back-to-back requests, no stalls, no bubbles.
        fork
            begin
                for (int i = 0; i < 256; i++) send(10'((i % 32) * 16 + 3), 10'((i / 32) * 8 + 1));
                in_valid = 1'b0;
            end
            begin
                int stalls  = 0;
                int bubbles = 0;
                for (int k = 0; k < 258; k++) begin
                    @(negedge clk);
                    if (k < 256 && !in_ready) stalls++;
                    if (k >= 2 && !out_valid) bubbles++;
                end
                check("stream_stalls", stalls, 0);
                check("stream_bubbles", bubbles, 0);
            end
        join
        drain();

`ifdef BLOCK_READER_WR_STALL_EN
        // Writer stall for three cycles during streaming.
        fork
            begin
                for (int i = 0; i < 20; i++) send(10'(i * 8), 10'(i * 12));
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 wr_we = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_rd_en", int'(rd_en), 0);
                    @(posedge clk); #1;
                end
                wr_we = 1'b0;
            end
        join
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/block_reader.md
Name: block_reader

Overview:
Read-side counterpart of the block-map writer: converts a stream of pixel coordinates into reads of the 128x128 x 6-bit block RAM and returns each block's 6-bit colour code in order.
- Sits between the VGA pixel-coordinate generator and the colour output stage.
- Handles the RAM's 1-cycle synchronous read latency.
- Provides full valid/ready backpressure with no lost or duplicated pixels.

Parameters:
ADDR_W, 14, block RAM address width ({row[6:0], col[6:0]}).
DATA_W, 6, block colour code width (RRGGBB 2:2:2).
COORD_W, 10, pixel coordinate width.
BLOCK_SHIFT, 2, log2 of block edge in pixels (4x4-pixel blocks).
BORDER_COLOR, 6'b000000, value returned for coordinates outside the map.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  coordinate request valid
in_ready  out  1  block accepts request this cycle
in_x  in  COORD_W  pixel column
in_y  in  COORD_W  pixel row
rd_en  out  1  block RAM read strobe
rd_addr  out  ADDR_W  block RAM read address
rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en
out_valid  out  1  colour output valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  colour code

Behaviour:
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Address mapping: col = in_x >> BLOCK_SHIFT and row = in_y >> BLOCK_SHIFT. rd_addr = {row[6:0], col[6:0]}.
- Out-of-range: a request is out-of-range if col >= 128 or row >= 128.
  - No RAM read is issued (rd_en = 0).
  - The pipeline still carries the request and returns BORDER_COLOR in order.
- rd_en/rd_addr are combinational from the input transfer. rd_en = transfer & in-range.
- Stage 1 register: in_flight (1 bit) plus oob flag, set on the cycle after an input transfer.
  - In that cycle, rd_data (or BORDER_COLOR if oob) is written into the output FIFO.
- Output FIFO:
  - 2 entries, DATA_W wide, wr_ptr/rd_ptr 1 bit each, count 0..2.
  - out_valid = (count != 0). out_data = mem[rd_ptr], registered storage.
- Flow control: in_ready = (count + in_flight - pop) < 2, where pop = out_valid & out_ready.
  - This guarantees a slot exists for every in-flight read, so rd_data is never dropped.
- Throughput and latency:
  - With out_ready held high: 1 request per cycle.
  - Latency from input transfer to out_valid is 2 cycles.
- Simultaneous push and pop with count = 2: allowed; count stays 2 and both pointers advance.
- Ordering: strict FIFO order; out-of-range results never overtake RAM results.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - count = 0, pointers = 0, in_flight = 0, oob = 0.
  - out_valid = 0, in_ready = 1 (combinational from reset state), rd_en = 0.
  - Reset mid-operation discards all in-flight and buffered pixels; the RAM response to a discarded read is ignored.
- Wrap-around: pointers wrap 1 -> 0 naturally. Coordinates are never clamped, only flagged oob.

Optional Feature:
BLOCK_READER_WR_STALL_EN
- Enabled: adds input port wr_we (1 bit), driven by the block writer's write enable on the shared single-port RAM.
  - While wr_we = 1, in_ready = 0 and rd_en = 0.
  - In-flight data and the FIFO drain normally.
- Disabled: port absent. The RAM is assumed true dual-port and reads are never stalled by writes.

Decomposition:
- Shared package (block_pkg): ADDR_W, DATA_W, MAP_COLS = 128, MAP_ROWS = 128, BLOCK_SHIFT, BORDER_COLOR, and the block-colour code constants used by the writer (6'b000000, 6'b011001, 6'b000111, 6'b001110).
- One sub-module: block_reader_fifo (2-entry, registered-output FIFO with count). The address mapping and flow-control logic stay in the top module.

Test Plan:
1. Reset, then check outputs: out_valid = 0, in_ready = 1, rd_en = 0 with rst low. Toggle rst low mid-stream: all outputs return to reset values immediately.
2. Address mapping and latency: in_x = 13, in_y = 6, RAM returns 6'b011001 -> rd_addr = 14'd131, then out_data = 6'b011001 with out_valid exactly 2 cycles after the input transfer.
3. Streaming: 256 back-to-back requests, out_ready = 1 -> in_ready stays 1, 256 outputs in order, zero bubbles after the first 2 cycles.
4. Backpressure: hold out_ready = 0 -> in_ready falls after exactly 2 transfers, no rd_data lost. Release -> outputs resume in order with no duplicates.
5. Out-of-range: in_x = 600, in_y = 10 between two in-range requests -> rd_en = 0 for that request, out_data = BORDER_COLOR in the middle position.
6. With BLOCK_READER_WR_STALL_EN defined: assert wr_we for 3 cycles during streaming -> in_ready = 0 and rd_en = 0 for those 3 cycles, no outputs lost or reordered.
